// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/stall sources and the stall controller.
// slave: the controller side; master: the pipeline/testbench side.
interface pipeline_stall_controller_if;
  logic        dmem_busywait;
  logic        imem_busywait;
  logic        load_use_hazard;
  logic        branch_taken;
  logic        muldiv_start;
  logic        muldiv_done;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        muldiv_ack;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  logic        mem_timeout;

  modport slave (
    input  dmem_busywait, imem_busywait, load_use_hazard, branch_taken,
           muldiv_start, muldiv_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, muldiv_ack,
           state, stall_cycles, flush_count, mem_timeout
  );

  modport master (
    output dmem_busywait, imem_busywait, load_use_hazard, branch_taken,
           muldiv_start, muldiv_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, muldiv_ack,
           state, stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Five-stage pipeline stall/flush controller. Enables and flushes are Mealy
// outputs of the registered state and the current hazard inputs; the state,
// performance counters and the sticky memory-timeout flag are registered.
module pipeline_stall_controller (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    DMEM_WAIT   = 2'b01,
    MULDIV_WAIT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;
  logic [7:0]  wait_q, wait_d;
  logic        mem_timeout_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, muldiv_ack;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v != 8'hFF) return v + 8'd1;
    return v;
  endfunction

  // Priority-ordered hazard resolution: drives enables/flushes and next state.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_ack   = 1'b0;
    state_d      = state_q;

    if (rst) begin
      // Bubbles everywhere while in reset; any in-flight operation is dropped.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
    end else if (bus.dmem_busywait) begin
      // Whole pipeline freezes; a pending mul/div completion waits too.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if (state_q == RUN) state_d = DMEM_WAIT;
    end else if ((state_q == MULDIV_WAIT) && !bus.muldiv_done) begin
      // Front end holds, MEM gets bubbles, WB drains what is already there.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b1;
    end else begin
      case (state_q)
        DMEM_WAIT:   state_d = RUN;
        MULDIV_WAIT: begin
          muldiv_ack = 1'b1;
          state_d    = RUN;
        end
        default:     state_d = bus.muldiv_start ? MULDIV_WAIT : RUN;
      endcase

      // Front-end hazards; a branch hidden behind a stall is re-presented later.
      if (bus.imem_busywait || bus.load_use_hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (bus.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    wait_d = bus.dmem_busywait ? sat_inc8(wait_q) : 8'd0;
  end

  // State, performance counters, dmem wait counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
      wait_q         <= 8'd0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= sat_inc16(stall_cycles_q, !pc_en);
      flush_count_q  <= sat_inc16(flush_count_q, if_id_flush);
      wait_q         <= wait_d;
      if (wait_d == 8'hFF) mem_timeout_q <= 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.muldiv_ack   = muldiv_ack;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
  assign bus.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: a rule-level model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_stall_controller;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_stall_controller_if bus();

  pipeline_stall_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic i, input logic l,
                       input logic b, input logic s, input logic dn);
    rst                 = r;
    bus.dmem_busywait   = d;
    bus.imem_busywait   = i;
    bus.load_use_hazard = l;
    bus.branch_taken    = b;
    bus.muldiv_start    = s;
    bus.muldiv_done     = dn;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 waiting on data memory, 2 waiting on mul/div
  int m_mode, m_stall, m_flush, m_wait;
  bit m_tmo, armed;

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, ack}
  function automatic logic [8:0] model_out(int mode, logic r, logic d, logic i,
                                           logic l, logic b, logic dn);
    int winner;
    logic ack;
    ack = 1'b0;
    if (r)                     winner = 1;
    else if (d)                winner = 2;
    else if (mode == 2 && !dn) winner = 3;
    else if (i || l)           winner = 4;
    else if (b)                winner = 5;
    else                       winner = 0;
    if (!r && !d && mode == 2 && dn) ack = 1'b1;
    case (winner)
      1:       return 9'b11111_111_0;
      2:       return 9'b00000_000_0;
      3:       return 9'b00001_001_0;
      4:       return {8'b00111_010, ack};
      5:       return {8'b11111_110, ack};
      default: return {8'b11111_000, ack};
    endcase
  endfunction

  initial begin
    logic [8:0] e;
    int n_mode, n_stall, n_flush, n_wait;
    bit n_tmo, r_s;
    armed = 0;
    forever begin
      mid();
      e = model_out(m_mode, rst, bus.dmem_busywait, bus.imem_busywait,
                    bus.load_use_hazard, bus.branch_taken, bus.muldiv_done);
      if (armed) begin
        chk("m_pc_en",        bus.pc_en,        e[8]);
        chk("m_if_id_en",     bus.if_id_en,     e[7]);
        chk("m_id_ex_en",     bus.id_ex_en,     e[6]);
        chk("m_ex_mem_en",    bus.ex_mem_en,    e[5]);
        chk("m_mem_wb_en",    bus.mem_wb_en,    e[4]);
        chk("m_if_id_flush",  bus.if_id_flush,  e[3]);
        chk("m_id_ex_flush",  bus.id_ex_flush,  e[2]);
        chk("m_ex_mem_flush", bus.ex_mem_flush, e[1]);
        chk("m_muldiv_ack",   bus.muldiv_ack,   e[0]);
        chk("m_state",        bus.state,        m_mode);
        chk("m_stall_cycles", bus.stall_cycles, m_stall);
        chk("m_flush_count",  bus.flush_count,  m_flush);
        chk("m_mem_timeout",  bus.mem_timeout,  m_tmo);
      end
      r_s = rst;
      if (rst) begin
        n_mode = 0; n_stall = 0; n_flush = 0; n_wait = 0; n_tmo = 0;
      end else begin
        if (bus.dmem_busywait)                    n_mode = (m_mode == 0) ? 1 : m_mode;
        else if (m_mode == 2 && !bus.muldiv_done) n_mode = 2;
        else if (m_mode == 0 && bus.muldiv_start) n_mode = 2;
        else                                      n_mode = 0;
        n_stall = (e[8] == 1'b0 && m_stall < 65535) ? m_stall + 1 : m_stall;
        n_flush = (e[3] == 1'b1 && m_flush < 65535) ? m_flush + 1 : m_flush;
        n_wait  = bus.dmem_busywait ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        n_tmo   = m_tmo || (n_wait == 255);
      end
      @(posedge clk);
      m_mode = n_mode; m_stall = n_stall; m_flush = n_flush;
      m_wait = n_wait; m_tmo = n_tmo;
      if (r_s) armed = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    total = 0;
    bad   = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    go();
    mid();
    chk("rst_pc_en",        bus.pc_en,        1);
    chk("rst_if_id_flush",  bus.if_id_flush,  1);
    chk("rst_ex_mem_flush", bus.ex_mem_flush, 1);
    chk("rst_muldiv_ack",   bus.muldiv_ack,   0);
    go();

    // reset released, idle five cycles
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (5) go();
    mid();
    chk("idle_state",     bus.state,        0);
    chk("idle_pc_en",     bus.pc_en,        1);
    chk("idle_mem_wb_en", bus.mem_wb_en,    1);
    chk("idle_stall",     bus.stall_cycles, 0);
    go();

    // data memory stall for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      mid();
      chk("dmem_pc_en",     bus.pc_en,     0);
      chk("dmem_mem_wb_en", bus.mem_wb_en, 0);
      if (k > 0) chk("dmem_state", bus.state, 1);
      go();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("dmem_last_state", bus.state,        1);
    chk("dmem_stall",      bus.stall_cycles, 3);
    chk("dmem_rel_pc_en",  bus.pc_en,        1);
    go();
    mid();
    chk("dmem_back_run", bus.state, 0);
    go();

    // mul/div: start, four wait cycles, done
    drive(0, 0, 0, 0, 0, 1, 0);
    mid();
    chk("md_start_pc_en", bus.pc_en,        1);
    chk("md_start_flush", bus.ex_mem_flush, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("md_wait_state",  bus.state,        2);
      chk("md_wait_flush",  bus.ex_mem_flush, 1);
      chk("md_wait_pc_en",  bus.pc_en,        0);
      chk("md_wait_wb_en",  bus.mem_wb_en,    1);
      chk("md_wait_ack",    bus.muldiv_ack,   0);
      go();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    mid();
    chk("md_ack",       bus.muldiv_ack,   1);
    chk("md_ack_pc_en", bus.pc_en,        1);
    chk("md_ack_flush", bus.ex_mem_flush, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("md_after_ack",   bus.muldiv_ack,   0);
    chk("md_after_state", bus.state,        0);
    chk("md_after_stall", bus.stall_cycles, 7);
    go();

    // load-use and branch together: stall wins, no flush of IF/ID
    drive(0, 0, 0, 1, 1, 0, 0);
    mid();
    chk("lu_br_pc_en",    bus.pc_en,       0);
    chk("lu_br_idex_fl",  bus.id_ex_flush, 1);
    chk("lu_br_ifid_fl",  bus.if_id_flush, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("lu_br_flushcnt", bus.flush_count,  0);
    chk("lu_br_stall",    bus.stall_cycles, 8);
    go();

    // branch alone
    drive(0, 0, 0, 0, 1, 0, 0);
    mid();
    chk("br_ifid_fl", bus.if_id_flush, 1);
    chk("br_idex_fl", bus.id_ex_flush, 1);
    chk("br_pc_en",   bus.pc_en,       1);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("br_flushcnt", bus.flush_count, 1);
    go();

    // instruction memory stall
    drive(0, 0, 1, 0, 0, 0, 0);
    mid();
    chk("imem_pc_en",   bus.pc_en,       0);
    chk("imem_ifid_en", bus.if_id_en,    0);
    chk("imem_idex_fl", bus.id_ex_flush, 1);
    chk("imem_idex_en", bus.id_ex_en,    1);
    chk("imem_exm_en",  bus.ex_mem_en,   1);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("imem_stall", bus.stall_cycles, 9);
    go();

    // branch masked by data memory stall
    drive(0, 1, 0, 0, 1, 0, 0);
    mid();
    chk("mask_ifid_fl", bus.if_id_flush, 0);
    chk("mask_pc_en",   bus.pc_en,       0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("mask_flushcnt", bus.flush_count,  1);
    chk("mask_stall",    bus.stall_cycles, 10);
    chk("mask_state",    bus.state,        1);
    go();

    // mul/div done ignored under a data memory stall
    drive(0, 0, 0, 0, 0, 1, 0);
    go();
    drive(0, 1, 0, 0, 0, 0, 1);
    mid();
    chk("mdd_ack_held",  bus.muldiv_ack, 0);
    chk("mdd_pc_en",     bus.pc_en,      0);
    go();
    mid();
    chk("mdd_state_hold", bus.state,      2);
    chk("mdd_ack_held2",  bus.muldiv_ack, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 1);
    mid();
    chk("mdd_ack", bus.muldiv_ack, 1);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("mdd_state_run", bus.state,        0);
    chk("mdd_stall",     bus.stall_cycles, 12);
    go();

    // reset in the middle of a mul/div wait
    drive(0, 0, 0, 0, 0, 1, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    go();
    drive(1, 0, 0, 0, 0, 0, 1);
    mid();
    chk("rstmd_ack",   bus.muldiv_ack,   0);
    chk("rstmd_pc_en", bus.pc_en,        1);
    chk("rstmd_fl",    bus.ex_mem_flush, 1);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rstmd_state", bus.state,        0);
    chk("rstmd_stall", bus.stall_cycles, 0);
    chk("rstmd_ack2",  bus.muldiv_ack,   0);
    go();

    // long data memory stall: timeout after 255 edges
    for (int i = 1; i <= 260; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      mid();
      if (i == 255) begin
        chk("tmo_before", bus.mem_timeout,  0);
        chk("tmo_stall",  bus.stall_cycles, 254);
      end
      if (i == 256) chk("tmo_set", bus.mem_timeout, 1);
      go();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("tmo_stall260", bus.stall_cycles, 260);
    chk("tmo_sticky",   bus.mem_timeout,  1);
    chk("tmo_state",    bus.state,        1);
    go();
    repeat (3) go();
    mid();
    chk("tmo_sticky2", bus.mem_timeout, 1);
    go();
    drive(1, 0, 0, 0, 0, 0, 0);
    go();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("tmo_cleared", bus.mem_timeout,  0);
    chk("tmo_stall0",  bus.stall_cycles, 0);
    go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The block SHALL provide the following inputs: dmem_busywait 1 (data memory stall); imem_busywait 1 (instruction memory stall); load_use_hazard 1 (ID instruction depends on EX load); branch_taken 1 (EX-stage redirect); muldiv_start 1 (EX issues multi-cycle mul/div); muldiv_done 1 (result ready, held high until ack).
REQ-003 The block SHALL provide the following outputs: pc_en 1, if_id_en 1, id_ex_en 1, ex_mem_en 1, mem_wb_en 1 (stage-register write enables).
REQ-004 The block SHALL provide if_id_flush 1, id_ex_flush 1 and ex_mem_flush 1 outputs, each loading a bubble (reg_write=0, mem_read=0, mem_write=0) into that register on the next edge.
REQ-005 The block SHALL provide the following outputs: muldiv_ack 1 (one-cycle acknowledge); state 2 (00 RUN, 01 DMEM_WAIT, 10 MULDIV_WAIT); stall_cycles 16 (performance counter); flush_count 16 (performance counter); mem_timeout 1 (sticky error).

Function
REQ-006 Enable and flush outputs SHALL be combinational (Mealy) from state and current inputs; state, counters and mem_timeout SHALL be registered.
REQ-007 Default (no condition active) SHALL be all enables 1, all flushes 0, muldiv_ack 0.
REQ-008 Conditions SHALL be evaluated in the priority order dmem_busywait > MULDIV_WAIT-not-done > imem_busywait > load_use_hazard > branch_taken; only the highest active condition drives outputs.
REQ-009 dmem_busywait=1, in any state, SHALL drive all five enables to 0 and all flushes to 0; from RUN the next state SHALL be DMEM_WAIT.
REQ-010 In DMEM_WAIT with dmem_busywait=0, the block SHALL apply the default outputs and the next state SHALL be RUN.
REQ-011 In RUN, muldiv_start=1 (with no dmem stall) SHALL select MULDIV_WAIT as next state; the start cycle itself SHALL use the default outputs.
REQ-012 In MULDIV_WAIT with muldiv_done=0, the block SHALL drive pc_en, if_id_en, id_ex_en and ex_mem_en to 0, ex_mem_flush to 1 and mem_wb_en to 1.
REQ-013 In MULDIV_WAIT with muldiv_done=1 and dmem_busywait=0, the block SHALL drive muldiv_ack=1 and default enables that cycle, and the next state SHALL be RUN.
REQ-014 muldiv_done SHALL be ignored while dmem_busywait=1, and the state SHALL be held in MULDIV_WAIT.
REQ-015 imem_busywait (highest active) SHALL drive pc_en=0, if_id_en=0 and id_ex_flush=1; all other enables SHALL be 1.
REQ-016 load_use_hazard (highest active) SHALL drive pc_en=0, if_id_en=0 and id_ex_flush=1.
REQ-017 branch_taken (highest active) SHALL drive pc_en=1, if_id_flush=1 and id_ex_flush=1.
REQ-018 branch_taken masked by a higher-priority condition SHALL produce no flush; the EX stage re-presents the branch after the stall.
REQ-019 stall_cycles SHALL increment by 1 on each edge where pc_en=0, saturating at 0xFFFF.
REQ-020 flush_count SHALL increment by 1 on each edge where if_id_flush=1, saturating at 0xFFFF.
REQ-021 An 8-bit wait counter SHALL count consecutive cycles with dmem_busywait=1 and clear on any cycle where dmem_busywait=0.
REQ-022 mem_timeout SHALL be set on the edge where the wait counter reaches 255 and SHALL stay 1 until reset.

Reset
REQ-023 rst=1 at a rising edge SHALL set state=RUN, stall_cycles=0, flush_count=0, the wait counter to 0 and mem_timeout=0.
REQ-024 While rst=1, the block SHALL drive all enables to 1, all flushes to 1 and muldiv_ack to 0, regardless of other inputs.
REQ-025 Reset asserted mid-MULDIV_WAIT or mid-DMEM_WAIT SHALL abandon the operation with no muldiv_ack.

Verification
REQ-026 The bench SHALL cover: reset, then idle 5 cycles -> state=00, all enables 1, stall_cycles=0.
REQ-027 The bench SHALL cover: dmem_busywait high 3 cycles -> enables all 0 for 3 cycles, state=01 for those cycles, stall_cycles=3, then RUN.
REQ-028 The bench SHALL cover: muldiv_start pulse, muldiv_done after 4 wait cycles -> ex_mem_flush=1 for 4 cycles, then muldiv_ack=1 for exactly 1 cycle, then state=00.
REQ-029 The bench SHALL cover: load_use_hazard and branch_taken in the same cycle -> pc_en=0, id_ex_flush=1, if_id_flush=0, flush_count unchanged.
REQ-030 The bench SHALL cover: branch_taken alone for 1 cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_count=1.
REQ-031 The bench SHALL cover: dmem_busywait held 260 cycles -> mem_timeout=1 from cycle 255, stall_cycles=260; mem_timeout stays 1 after busywait drops and clears only on rst.
